isa_cmd_frontend: RTL and testbench
===================================

// Module: isa_cmd_frontend
// PURPOSE
//  Host-side command front end for the ISA bus-cycle sequencer. Accepts a byte stream
//  from the host link (command, address low/high, optional write data) and holds the
//  address, write data and request bits for the sequencer. Drives the sequencer's 8-bit
//  control input and captures ISA read data on its data_load strobe. Releases the request
//  on its control_reset strobe and returns read data to the host over a valid/ready handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles spent in S_WAIT before abort (used only with CMD_TIMEOUT_EN)
// PORTS
//  clk            in   1   system clock; all logic on posedge
//  reset          in   1   reset, synchronous, active-low
//  host_data      in   8   host byte
//  host_stb       in   1   host byte valid, one-cycle pulse
//  host_ack       out  1   byte accepted; one-cycle pulse
//  control_out    out  8   to sequencer control_in; [0]=read req, [1]=write req, [7:2]=0
//  control_reset  in   1   from sequencer, active-low: cycle complete
//  data_load      in   1   from sequencer, active-low: read data valid on isa_rdata
//  isa_addr       out  16  latched I/O address
//  isa_wdata      out  8   latched write data
//  isa_rdata      in   8   ISA data bus, read direction
//  rd_data        out  8   read result to host
//  rd_valid       out  1   rd_data valid; held until rd_ready
//  rd_ready       in   1   host takes rd_data
//  busy           out  1   high in every state except S_CMD
//  err            out  1   sticky timeout flag (constant 0 without CMD_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=S_CMD. Every output listed in PORTS is 0, incl.
//    control_out, isa_addr, isa_wdata, rd_data, host_ack, rd_valid, busy and err.
//    Reset mid-cycle abandons the operation; control_out is 0 from the next cycle.
//  - A byte is accepted at a posedge with host_stb=1 in S_CMD/S_ALO/S_AHI/S_DATA.
//    host_ack=1 for exactly the following cycle.
//  - host_stb in S_WAIT/S_RESP is ignored: no ack and no state change.
//  - Command byte: [0]=READ, [1]=WRITE, [7:2] ignored.
//    Exactly one of READ/WRITE set -> latch op, go to S_ALO.
//    Both set or neither set -> byte is acked and discarded; state stays S_CMD.
//  - S_ALO: isa_addr[7:0]<=byte, go to S_AHI.
//  - S_AHI: isa_addr[15:8]<=byte. Write op -> S_DATA. Read op -> S_WAIT.
//  - S_DATA: isa_wdata<=byte, go to S_WAIT.
//  - S_WAIT: control_out = {6'b0, op==WRITE, op==READ}. control_out is first high in the
//    cycle after the last byte is accepted, and stays constant until control_reset
//    is sampled low.
//  - S_WAIT, read op: at every posedge with data_load==0, rd_data<=isa_rdata
//    (the last sample wins).
//  - S_WAIT, posedge with control_reset==0: control_out<=0 (so the sequencer's IDLE
//    state sees no request and does not retrigger).
//    Write op -> S_CMD. Read op -> S_RESP.
//  - S_RESP: rd_valid=1 and rd_data stable. At a posedge with rd_ready=1: rd_valid<=0,
//    go to S_CMD.
//    rd_ready already high when rd_valid rises -> transfer at the next posedge; rd_valid
//    is high for exactly 1 cycle.
//  - control_reset or data_load low outside S_WAIT: ignored.
//  - isa_addr and isa_wdata change only when their byte is accepted; they are stable
//    throughout S_WAIT.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined:
//    - An 8-bit-min counter clears on entry to S_WAIT and increments each cycle in S_WAIT.
//    - When the count reaches TIMEOUT_CYCLES with no control_reset: control_out<=0,
//      err<=1, go to S_CMD. For a read, no rd_valid is raised.
//    - err stays 1 until the next command byte is accepted, which clears it.
//    - If control_reset==0 arrives on the expiry cycle, normal completion wins.
//  CMD_TIMEOUT_EN undefined: S_WAIT waits indefinitely; err is tied to 0; no counter logic.
// TESTING
//  1 Write: bytes 02,88,02,5A -> 4 host_ack pulses; isa_addr=0x0288, isa_wdata=0x5A;
//    control_out=0x02 until control_reset low, then 0x00; busy drops; no rd_valid.
//  2 Read: bytes 01,2C,02 -> control_out=0x01; isa_rdata=0xAA while data_load low ->
//    rd_valid=1, rd_data=0xAA; rd_ready held low 5 cycles -> rd_valid held; rd_ready=1 -> idle.
//  3 Illegal cmd 03 then 00 -> both acked; busy stays 0; control_out stays 0.
//    Next valid command is then accepted normally.
//  4 host_stb pulsed during S_WAIT and S_RESP -> no host_ack; isa_addr/isa_wdata unchanged.
//  5 reset low for 1 cycle mid-S_WAIT -> next cycle: control_out=0, busy=0, rd_valid=0,
//    isa_addr=0.
//  6 [CMD_TIMEOUT_EN, TIMEOUT_CYCLES=8] read with control_reset held high -> after 8 cycles
//    control_out=0, err=1, no rd_valid; next cmd byte 01 clears err.

Source files
------------

// File: rtl/isa_cmd_frontend.sv
// Host-side command front end for the ISA bus-cycle sequencer: collects command/address/data
// bytes, drives the sequencer request and returns read data. Optional abort timer: CMD_TIMEOUT_EN.
module isa_cmd_frontend #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  host_data,
    input  logic        host_stb,
    output logic        host_ack,
    output logic [7:0]  control_out,
    input  logic        control_reset,
    input  logic        data_load,
    output logic [15:0] isa_addr,
    output logic [7:0]  isa_wdata,
    input  logic [7:0]  isa_rdata,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        S_CMD  = 3'd0,
        S_ALO  = 3'd1,
        S_AHI  = 3'd2,
        S_DATA = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic op_write;
    logic accept;
    logic cmd_legal;
    logic done;
    logic timeout;

    // Bytes are only taken while collecting a command; WAIT/RESP ignore the host link.
    assign accept    = host_stb && ((state == S_CMD) || (state == S_ALO) ||
                                    (state == S_AHI) || (state == S_DATA));
    assign cmd_legal = host_data[0] ^ host_data[1];
    assign done      = (state == S_WAIT) && !control_reset;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Counter sits at zero outside S_WAIT, so it is already cleared on entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = (state == S_WAIT) && control_reset &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (accept && (state == S_CMD)) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_CMD;
        end else begin
            state <= state_next;
        end
    end

    // Normal completion is checked before the timeout so a late control_reset still wins.
    always_comb begin
        state_next = state;
        case (state)
            S_CMD:  if (accept && cmd_legal) state_next = S_ALO;
            S_ALO:  if (accept) state_next = S_AHI;
            S_AHI:  if (accept) state_next = op_write ? S_DATA : S_WAIT;
            S_DATA: if (accept) state_next = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    state_next = op_write ? S_CMD : S_RESP;
                end else if (timeout) begin
                    state_next = S_CMD;
                end
            end
            S_RESP: if (rd_ready) state_next = S_CMD;
            default: state_next = S_CMD;
        endcase
    end

    always_comb begin
        control_out = 8'h00;
        if (state == S_WAIT) begin
            control_out = {6'b0, op_write, !op_write};
        end
        busy     = (state != S_CMD);
        rd_valid = (state == S_RESP);
    end

    // Address and write data move only when their own byte is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            host_ack  <= 1'b0;
            op_write  <= 1'b0;
            isa_addr  <= 16'h0000;
            isa_wdata <= 8'h00;
            rd_data   <= 8'h00;
        end else begin
            host_ack <= accept;
            if ((state == S_CMD) && accept && cmd_legal) begin
                op_write <= host_data[1];
            end
            if ((state == S_ALO) && accept) begin
                isa_addr[7:0] <= host_data;
            end
            if ((state == S_AHI) && accept) begin
                isa_addr[15:8] <= host_data;
            end
            if ((state == S_DATA) && accept) begin
                isa_wdata <= host_data;
            end
            if ((state == S_WAIT) && !op_write && !data_load) begin
                rd_data <= isa_rdata;
            end
        end
    end

endmodule

// File: tb/tb_isa_cmd_frontend.sv
// Randomized self-checking bench for isa_cmd_frontend; a transaction-level model predicts
// the latched address/data, sequencer request and returned read byte.
module tb_isa_cmd_frontend;

`ifdef CMD_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  host_data = 8'h00;
    logic        host_stb = 1'b0;
    logic        host_ack;
    logic [7:0]  control_out;
    logic        control_reset = 1'b1;
    logic        data_load = 1'b1;
    logic [15:0] isa_addr;
    logic [7:0]  isa_wdata;
    logic [7:0]  isa_rdata = 8'h00;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr = 16'h0000;
    logic [7:0]  exp_wdata = 8'h00;
    logic [7:0]  exp_rd = 8'h00;

    isa_cmd_frontend #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .host_data(host_data), .host_stb(host_stb), .host_ack(host_ack),
        .control_out(control_out), .control_reset(control_reset), .data_load(data_load),
        .isa_addr(isa_addr), .isa_wdata(isa_wdata), .isa_rdata(isa_rdata),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge, half a cycle from the posedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        host_data = b;
        host_stb  = 1'b1;
        tick();
        host_stb  = 1'b0;
    endtask

    // One full host transaction, compared against the model at every cycle of interest.
    task automatic run_txn(input bit is_write, input logic [15:0] addr, input logic [7:0] wd,
                           input int wait_cycles, input int ready_delay, input bit stb_noise);
        logic [7:0] exp_ctl;
        logic [7:0] cmd;
        exp_ctl = is_write ? 8'h02 : 8'h01;
        cmd     = {6'($urandom), is_write, !is_write};
        applyStimulus(cmd);
        checkOutput("cmd_ack", host_ack, 1);
        checkOutput("cmd_busy", busy, 1);
        checkOutput("cmd_err_clear", err, 0);
        applyStimulus(addr[7:0]);
        checkOutput("alo_ack", host_ack, 1);
        applyStimulus(addr[15:8]);
        checkOutput("ahi_ack", host_ack, 1);
        exp_addr = addr;
        if (is_write) begin
            applyStimulus(wd);
            checkOutput("data_ack", host_ack, 1);
            exp_wdata = wd;
        end
        checkOutput("wait_ctl_first", control_out, exp_ctl);
        checkOutput("wait_addr", isa_addr, exp_addr);
        checkOutput("wait_wdata", isa_wdata, exp_wdata);
        for (int i = 0; i < wait_cycles; i++) begin
            data_load = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            isa_rdata = 8'($urandom);
            host_data = 8'($urandom);
            host_stb  = stb_noise;
            if (!data_load && !is_write) exp_rd = isa_rdata;
            tick();
            host_stb = 1'b0;
            checkOutput("wait_ctl", control_out, exp_ctl);
            checkOutput("wait_noack", host_ack, 0);
            checkOutput("wait_addr_hold", isa_addr, exp_addr);
            checkOutput("wait_wdata_hold", isa_wdata, exp_wdata);
        end
        data_load     = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
        isa_rdata     = 8'($urandom);
        if (!data_load && !is_write) exp_rd = isa_rdata;
        control_reset = 1'b0;
        rd_ready      = (ready_delay == 0);
        tick();
        control_reset = 1'b1;
        data_load     = 1'b1;
        checkOutput("done_ctl", control_out, 0);
        checkOutput("done_err", err, 0);
        if (is_write) begin
            rd_ready = 1'b0;
            checkOutput("wr_busy", busy, 0);
            checkOutput("wr_no_valid", rd_valid, 0);
        end else begin
            checkOutput("rd_valid", rd_valid, 1);
            checkOutput("rd_data", rd_data, exp_rd);
            for (int i = 1; i < ready_delay; i++) begin
                host_stb  = stb_noise;
                host_data = 8'($urandom);
                tick();
                host_stb = 1'b0;
                checkOutput("resp_hold_valid", rd_valid, 1);
                checkOutput("resp_hold_data", rd_data, exp_rd);
                checkOutput("resp_noack", host_ack, 0);
                checkOutput("resp_addr_hold", isa_addr, exp_addr);
            end
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            checkOutput("resp_taken_valid", rd_valid, 0);
            checkOutput("resp_taken_busy", busy, 0);
        end
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_ctl", control_out, 0);
        checkOutput("rst_addr", isa_addr, 0);
        checkOutput("rst_wdata", isa_wdata, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_ack", host_ack, 0);
        checkOutput("rst_valid", rd_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        reset = 1'b1;
        tick();

        $display("[TB] directed write 02 88 02 5A");
        run_txn(1'b1, 16'h0288, 8'h5A, 3, 0, 1'b0);

        $display("[TB] directed read 01 2C 02");
        run_txn(1'b0, 16'h022C, 8'h00, 2, 6, 1'b0);

        $display("[TB] illegal commands");
        applyStimulus(8'h03);
        checkOutput("ill03_ack", host_ack, 1);
        checkOutput("ill03_busy", busy, 0);
        checkOutput("ill03_ctl", control_out, 0);
        applyStimulus(8'h00);
        checkOutput("ill00_ack", host_ack, 1);
        checkOutput("ill00_busy", busy, 0);
        checkOutput("ill00_ctl", control_out, 0);
        run_txn(1'b0, 16'hBEEF, 8'h00, 1, 0, 1'b0);

        $display("[TB] host strobes during wait and response");
        run_txn(1'b1, 16'h1234, 8'hC3, 4, 0, 1'b1);
        run_txn(1'b0, 16'h4321, 8'h00, 4, 4, 1'b1);

        $display("[TB] reset in the middle of a read");
        applyStimulus(8'h01);
        applyStimulus(8'h34);
        applyStimulus(8'h12);
        checkOutput("pre_rst_ctl", control_out, 8'h01);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_addr  = 16'h0000;
        exp_wdata = 8'h00;
        exp_rd    = 8'h00;
        checkOutput("mid_rst_ctl", control_out, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_valid", rd_valid, 0);
        checkOutput("mid_rst_addr", isa_addr, exp_addr);
        checkOutput("mid_rst_wdata", isa_wdata, exp_wdata);
        checkOutput("mid_rst_rd", rd_data, exp_rd);

`ifdef CMD_TIMEOUT_EN
        $display("[TB] read abandoned by the sequencer");
        applyStimulus(8'h01);
        applyStimulus(8'h10);
        applyStimulus(8'h00);
        exp_addr = 16'h0010;
        for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
            checkOutput("to_ctl_held", control_out, 8'h01);
            tick();
        end
        checkOutput("to_ctl_last", control_out, 8'h01);
        tick();
        checkOutput("to_ctl_drop", control_out, 0);
        checkOutput("to_err_set", err, 1);
        checkOutput("to_no_valid", rd_valid, 0);
        checkOutput("to_busy", busy, 0);
        tick();
        checkOutput("to_err_sticky", err, 1);
        run_txn(1'b0, 16'h0077, 8'h00, 2, 0, 1'b0);
`endif

        $display("[TB] randomized transactions");
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus({6'($urandom), 2'b11});
                checkOutput("rnd_ill_ack", host_ack, 1);
                checkOutput("rnd_ill_busy", busy, 0);
            end
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                    $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
